// File: rtl/shift_add_mul_seq.sv
// shift_add_mul_seq: multi-cycle unsigned shift-and-add multiplier sequencer.
//
// Produces a WIDTH x WIDTH unsigned product in WIDTH step cycles. It drives an
// external combinational ripple adder, which is not part of this block. Each RUN
// cycle performs one add-and-shift step:
//   - Adds M to ACC when Q[0] is set.
//   - Shifts {carry, sum, Q} right by one.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled in IDLE and DONE only
//   a, b     in   multiplicand / multiplier, captured on an accepted start
//   busy     out  high while stepping (RUN)
//   done     out  one-cycle completion pulse (DONE)
//   product  out  2*WIDTH result register, held until the next completion
//   add_a    out  adder operand A (ACC)
//   add_b    out  adder operand B (M or 0)
//   add_ci   out  adder carry-in (tied low)
//   add_s    in   adder sum
//   add_co   in   adder carry-out
module shift_add_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_ci,
    input  logic [WIDTH-1:0]     add_s,
    input  logic                 add_co
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            // DONE accepts a new start exactly like IDLE so that operations can
            // issue back to back with no idle cycle in between.
            StIdle, StDone: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = CntW'(WIDTH);
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end

            StRun: begin
                // The carry-out is shifted into the top of ACC. This keeps the
                // full sum, so no step can overflow.
                acc_d = {add_co, add_s[WIDTH-1:1]};
                q_d   = {add_s[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    // Final step: the shifted {ACC, Q} is the full product.
                    product_d = {add_co, add_s, q_q[WIDTH-1:1]};
                    acc_d     = '0;
                    state_d   = StDone;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign product = product_q;

    assign add_a  = acc_q;
    assign add_b  = q_q[0] ? m_q : '0;
    assign add_ci = 1'b0;

endmodule

// File: tb/tb_shift_add_mul_seq.sv
module tb_shift_add_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_ci;
    logic [7:0]  add_s;
    logic        add_co;
    logic [8:0]  sum;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-step adder operands, captured while busy.
    logic [7:0] sa[$];
    logic [7:0] sb[$];
    logic       sco[$];

    shift_add_mul_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_ci  (add_ci),
        .add_s   (add_s),
        .add_co  (add_co)
    );

    // Behavioural zero-latency adder.
    assign sum    = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_ci};
    assign add_s  = sum[7:0];
    assign add_co = sum[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one multiply from IDLE.
    // Then wait for done, counting busy cycles and logging adder traffic.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          output int nbusy, output logic [15:0] prod, output bit tmo);
        sa.delete(); sb.delete(); sco.delete();
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        nbusy = 0; tmo = 1'b1; prod = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) begin
                nbusy++;
                sa.push_back(add_a); sb.push_back(add_b); sco.push_back(add_co);
            end
            if (done) begin
                prod = product; tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, product} !== 18'd0)
            $display("FAIL reset_state busy=%b done=%b product=%h, required 0/0/0000",
                     busy, done, product);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int nb; logic [15:0] p; bit tmo; bit zero_seen;
        run_op(8'd13, 8'd11, nb, p, tmo);
        n_checks++;
        if (tmo) $display("FAIL basic_timeout no done within bound");
        else n_pass++;
        n_checks++;
        if (nb !== 8) $display("FAIL basic_busy_cycles got %0d required 8", nb);
        else n_pass++;
        n_checks++;
        if (p !== 16'h008F) $display("FAIL basic_product got %h required 008F", p);
        else n_pass++;
        // Multiplier bit k is Q[0] at step k; 11 = 1011b, so step 2 adds zero.
        zero_seen = 1'b0;
        for (int k = 0; k < 8 && k < sb.size(); k++) begin
            logic [7:0] eb;
            eb = ((11 >> k) & 1) != 0 ? 8'd13 : 8'd0;
            if (eb == 8'd0 && sb[k] === 8'd0) zero_seen = 1'b1;
            n_checks++;
            if (sb[k] !== eb) $display("FAIL basic_add_b step %0d got %h required %h", k, sb[k], eb);
            else n_pass++;
        end
        n_checks++;
        if (!zero_seen) $display("FAIL basic_add_b_zero got 0 zero steps required 1+");
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy, done, product} !== {2'b00, 16'h008F})
            $display("FAIL basic_hold busy=%b done=%b product=%h required 0/0/008F",
                     busy, done, product);
        else n_pass++;
    endtask

    task automatic test_max();
        int nb; logic [15:0] p; bit tmo; int nco;
        run_op(8'hFF, 8'hFF, nb, p, tmo);
        nco = 0;
        foreach (sco[k]) if (sco[k]) nco++;
        n_checks++;
        if (tmo || p !== 16'hFE01) $display("FAIL max_product got %h tmo=%0d required FE01", p, tmo);
        else n_pass++;
        n_checks++;
        if (nco < 2) $display("FAIL max_carry_steps got %0d required >=2", nco);
        else n_pass++;
    endtask

    task automatic test_zero();
        int nb; logic [15:0] p; bit tmo;
        run_op(8'h00, 8'hA5, nb, p, tmo);
        n_checks++;
        if (tmo || p !== 16'h0000 || nb !== 8)
            $display("FAIL zero_a got %h busy=%0d tmo=%0d required 0000/8/0", p, nb, tmo);
        else n_pass++;
        run_op(8'h5A, 8'h00, nb, p, tmo);
        n_checks++;
        if (tmo || p !== 16'h0000 || nb !== 8)
            $display("FAIL zero_b got %h busy=%0d tmo=%0d required 0000/8/0", p, nb, tmo);
        else n_pass++;
    endtask

    task automatic test_random();
        int nb; logic [15:0] p; bit tmo;
        for (int t = 0; t < 20; t++) begin
            logic [7:0] ra, rb; int unsigned exp_p;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            exp_p = int'(ra) * int'(rb);
            run_op(ra, rb, nb, p, tmo);
            n_checks++;
            if (tmo || p !== exp_p[15:0] || nb !== 8)
                $display("FAIL rand_product %0d*%0d got %h busy=%0d required %h/8",
                         ra, rb, p, nb, exp_p[15:0]);
            else n_pass++;
            // ACC at step k is the partial product of the low k multiplier bits, shifted by k.
            for (int k = 0; k < 8 && k < sa.size(); k++) begin
                int unsigned ea; int unsigned eb;
                ea = (int'(ra) * (int'(rb) & ((1 << k) - 1))) >> k;
                eb = ((rb >> k) & 1) != 0 ? int'(ra) : 0;
                n_checks++;
                if (sa[k] !== ea[7:0] || sb[k] !== eb[7:0])
                    $display("FAIL rand_step %0d got a=%h b=%h required a=%h b=%h",
                             k, sa[k], sb[k], ea[7:0], eb[7:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_start_busy();
        int ndone; int nbusy;
        @(negedge clk);
        a = 8'd3; b = 8'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) ndone++;
            if (nbusy == 3 && busy) begin a = 8'd9; b = 8'd9; start = 1'b1; end
            else start = 1'b0;
        end
        n_checks++;
        if (ndone !== 1) $display("FAIL busy_start_dones got %0d required 1", ndone);
        else n_pass++;
        n_checks++;
        if (product !== 16'h000C) $display("FAIL busy_start_product got %h required 000C", product);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nb; logic [15:0] p; bit tmo; int cnt; bit seen_done;
        @(negedge clk);
        a = 8'd7; b = 8'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 5; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, product} !== 18'd0)
            $display("FAIL reset_mid busy=%b done=%b product=%h required 0/0/0000",
                     busy, done, product);
        else n_pass++;
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done) $display("FAIL reset_abandon got activity after reset required none");
        else n_pass++;
        run_op(8'd7, 8'd7, nb, p, tmo);
        n_checks++;
        if (tmo || p !== 16'h0031) $display("FAIL reset_rerun got %h tmo=%0d required 0031", p, tmo);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit got1; bit got2;
        @(negedge clk);
        a = 8'd2; b = 8'd3; start = 1'b1;
        @(posedge clk); #1 a = 8'd6; b = 8'd7;
        got1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin got1 = 1'b1; break; end
        end
        n_checks++;
        if (!got1 || product !== 16'h0006)
            $display("FAIL b2b_first got %h done_seen=%0d required 0006", product, got1);
        else n_pass++;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_reenter busy=%b done=%b required 1/0", busy, done);
        else n_pass++;
        got2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin got2 = 1'b1; break; end
        end
        n_checks++;
        if (!got2 || product !== 16'h002A)
            $display("FAIL b2b_second got %h done_seen=%0d required 002A", product, got2);
        else n_pass++;
    endtask

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (rst_n && busy && done) begin
            n_checks++;
            $display("FAIL busy_done_exclusive both high at %0t", $time);
        end
    end

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_random();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
